// File: rtl/rs_pkg.sv
// GF(2^8) arithmetic, generator-polynomial construction and FSM state type
// shared by the parallel Reed-Solomon encoder.
package rs_pkg;

  localparam int unsigned GF_W          = 8;
  localparam logic [8:0]  PRIM_POLY_DEF = 9'h11D;

  typedef logic [GF_W-1:0] gf_t;
  typedef gf_t [255:0]     gpoly_t;

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  function automatic gf_t gf_mul(input gf_t a, input gf_t b,
                                 input logic [8:0] poly = PRIM_POLY_DEF);
    gf_t acc;
    gf_t aa;
    acc = '0;
    aa  = a;
    for (int unsigned i = 0; i < GF_W; i++) begin
      if (b[i]) acc ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? poly[7:0] : 8'h00);
    end
    return acc;
  endfunction

  // g[d] is the coefficient of x^d; the monic leading term is kept in g[npar].
  function automatic gpoly_t gen_poly(input int unsigned npar, input int unsigned fcr,
                                      input logic [8:0] poly);
    gpoly_t g;
    gf_t    root;
    g    = '0;
    g[0] = 8'd1;
    root = 8'd1;
    for (int unsigned e = 0; e < fcr; e++) root = gf_mul(root, 8'd2, poly);
    for (int unsigned i = 0; i < npar; i++) begin
      for (int unsigned j = i + 1; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root, poly);
      g[0] = gf_mul(g[0], root, poly);
      root = gf_mul(root, 8'd2, poly);
    end
    return g;
  endfunction

endpackage

// File: rtl/rs_lfsr_step.sv
// One-symbol systematic RS division step: folds a symbol into the parity
// remainder using constant generator-coefficient multipliers.
module rs_lfsr_step
  import rs_pkg::*;
#(
  parameter int unsigned NPAR      = 16,
  parameter int unsigned FCR       = 0,
  parameter logic [8:0]  PRIM_POLY = PRIM_POLY_DEF
) (
  input  logic [NPAR-1:0][7:0] i_par,
  input  logic [7:0]           i_sym,
  output logic [NPAR-1:0][7:0] o_par
);

  localparam gpoly_t G = gen_poly(NPAR, FCR, PRIM_POLY);

  logic [7:0] w_fb;

  assign w_fb = i_sym ^ i_par[NPAR-1];

  always_comb begin
    o_par[0] = gf_mul(w_fb, G[0], PRIM_POLY);
    for (int unsigned i = 1; i < NPAR; i++) begin
      o_par[i] = i_par[i-1] ^ gf_mul(w_fb, G[i], PRIM_POLY);
    end
  end

endmodule

// File: rtl/rs_encoder_xp.sv
// Parallel systematic RS encoder: P symbols per beat, data beats pass through
// with one cycle latency, then NPAR/P parity beats follow.
module rs_encoder_xp
  import rs_pkg::*;
#(
  parameter int unsigned P         = 4,
  parameter int unsigned K         = 236,
  parameter int unsigned NPAR      = 16,
  parameter int unsigned FCR       = 0,
  parameter logic [8:0]  PRIM_POLY = PRIM_POLY_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [8*P-1:0] din,
  input  logic           in_valid,
  input  logic           in_sof,
  output logic           in_ready,
  output logic [8*P-1:0] dout,
  output logic           out_valid,
  output logic           out_sof,
  output logic           out_eof,
  output logic           out_parity,
  output logic           frame_err
);

  localparam int unsigned KB      = K / P;
  localparam int unsigned PB      = NPAR / P;
  localparam int unsigned CNT_MAX = (KB > PB) ? KB : PB;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t KB_LAST = cnt_t'(KB - 1);
  localparam cnt_t PB_LAST = cnt_t'(PB - 1);

  state_t               r_state, w_state_n;
  cnt_t                 r_cnt, w_cnt_n;
  logic [NPAR-1:0][7:0] r_par, w_par_n, w_seed;
  logic [NPAR-1:0][7:0] w_chain [0:P];
  logic [8*P-1:0]       r_dout, w_dout_n;
  logic                 r_valid, r_sof, r_eof, r_parity, r_err;
  logic                 w_valid_n, w_sof_n, w_eof_n, w_parity_n, w_err_n;
  logic                 w_acc;

  assign in_ready   = (r_state != PARITY);
  assign w_acc      = in_valid & in_ready;
  assign dout       = r_dout;
  assign out_valid  = r_valid;
  assign out_sof    = r_sof;
  assign out_eof    = r_eof;
  assign out_parity = r_parity;
  assign frame_err  = r_err;

  // A start marker always restarts the division from a zero remainder.
  assign w_seed     = (r_state == DATA && !in_sof) ? r_par : '0;
  assign w_chain[0] = w_seed;

  for (genvar gi = 0; gi < P; gi++) begin : g_step
    rs_lfsr_step #(.NPAR(NPAR), .FCR(FCR), .PRIM_POLY(PRIM_POLY)) u_step (
      .i_par (w_chain[gi]),
      .i_sym (din[8*P-1-8*gi -: 8]),
      .o_par (w_chain[gi+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_par    <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_sof    <= 1'b0;
      r_eof    <= 1'b0;
      r_parity <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_par    <= w_par_n;
      r_dout   <= w_dout_n;
      r_valid  <= w_valid_n;
      r_sof    <= w_sof_n;
      r_eof    <= w_eof_n;
      r_parity <= w_parity_n;
      r_err    <= w_err_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_acc && in_sof) begin
          w_state_n = (KB == 1) ? PARITY : DATA;
          w_cnt_n   = (KB == 1) ? cnt_t'(0) : cnt_t'(1);
        end
      end
      DATA: begin
        if (w_acc) begin
          if (in_sof) begin
            w_state_n = (KB == 1) ? PARITY : DATA;
            w_cnt_n   = (KB == 1) ? cnt_t'(0) : cnt_t'(1);
          end else if (r_cnt == KB_LAST) begin
            w_state_n = PARITY;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n   = r_cnt + cnt_t'(1);
          end
        end
      end
      PARITY: begin
        if (r_cnt == PB_LAST) begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n   = r_cnt + cnt_t'(1);
        end
      end
      default: begin
        w_state_n = IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    w_dout_n   = r_dout;
    w_par_n    = r_par;
    w_valid_n  = 1'b0;
    w_sof_n    = 1'b0;
    w_eof_n    = 1'b0;
    w_parity_n = 1'b0;
    w_err_n    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          if (in_sof) begin
            w_dout_n  = din;
            w_par_n   = w_chain[P];
            w_valid_n = 1'b1;
            w_sof_n   = 1'b1;
          end else begin
            w_err_n   = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_acc) begin
          w_dout_n  = din;
          w_par_n   = w_chain[P];
          w_valid_n = 1'b1;
          w_sof_n   = in_sof;
          w_err_n   = in_sof;
        end
      end
      PARITY: begin
        // Highest-degree parity leaves first; the register drains upward.
        w_dout_n   = r_par[NPAR-1 -: P];
        w_par_n    = r_par << (8 * P);
        w_valid_n  = 1'b1;
        w_parity_n = 1'b1;
        w_eof_n    = (r_cnt == PB_LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rs_encoder_xp.sv
// Directed bench for rs_encoder_xp: table of frame scenarios checked against a
// log-table long-division model and syndrome evaluation, plus corner sequences.
module tb_rs_encoder_xp;
  import rs_pkg::*;

  localparam int P = 4, K = 236, NPAR = 16, FCR = 0;
  localparam int KB = K / P, PB = NPAR / P;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [8*P-1:0] din = '0;
  logic           in_valid = 1'b0, in_sof = 1'b0;
  logic           in_ready;
  logic [8*P-1:0] dout;
  logic           out_valid, out_sof, out_eof, out_parity, frame_err;

  always #5 clk = ~clk;

  rs_encoder_xp #(.P(P), .K(K), .NPAR(NPAR), .FCR(FCR), .PRIM_POLY(9'h11D)) dut (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .dout(dout), .out_valid(out_valid), .out_sof(out_sof),
    .out_eof(out_eof), .out_parity(out_parity), .frame_err(frame_err)
  );

  int n_checks = 0, n_errors = 0;

  int gexp [0:254];
  int glog [0:255];
  int bg   [0:NPAR];
  int mw   [0:K+NPAR-1];
  int mpar [0:NPAR-1];

  // monitor state, written only by the monitor process
  logic [8*P-1:0] ob_d [$];
  logic [2:0]     ob_f [$];
  int n_err = 0, n_rdy_low = 0, n_lat_bad = 0, n_par_seen = 0, n_eof = 0;
  bit prev_acc = 1'b0;

  always @(negedge clk) begin
    if (out_valid) begin
      ob_d.push_back(dout);
      ob_f.push_back({out_sof, out_eof, out_parity});
      if (!out_parity && !prev_acc) n_lat_bad++;
      if (out_parity) n_par_seen++;
      if (out_eof) n_eof++;
    end
    if (frame_err) n_err++;
    if (!in_ready) n_rdy_low++;
    prev_acc = in_valid && in_ready && !rst;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int gfm(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  function automatic int sym(input int pat, input int idx);
    case (pat)
      0:       return 0;
      1:       return (idx == K - 1) ? 1 : 0;
      2:       return idx % 256;
      3:       return (idx * 37 + 11) % 256;
      default: return (255 - idx) % 256;
    endcase
  endfunction

  // Remainder of m(x)*x^NPAR by g(x) via long division; mpar[0] is highest degree.
  task automatic model_parity(input int pat);
    for (int i = 0; i < K + NPAR; i++) mw[i] = (i < K) ? sym(pat, i) : 0;
    for (int i = 0; i < K; i++) begin
      int c;
      c = mw[i];
      if (c != 0)
        for (int j = 1; j <= NPAR; j++) mw[i+j] = mw[i+j] ^ gfm(c, bg[NPAR-j]);
    end
    for (int i = 0; i < NPAR; i++) mpar[i] = mw[K+i];
  endtask

  task automatic drive_beats(input int pat, input int nb, input int sa, input int sb);
    for (int b = 0; b < nb; b++) begin
      if (b == sa || b == sb) begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      for (int l = 0; l < P; l++) din[8*P-1-8*l -: 8] = 8'(sym(pat, b*P + l));
      in_valid = 1'b1;
      in_sof   = (b == 0);
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int pat; int pre_pat; int abort_at; int sa; int sb;
    int exp_beats; int exp_err; int exp_rdy_low;
  } vec_t;

  task automatic analyze(input vec_t v, input int b0, input int e0, input int r0, input int l0);
    int nb, s0, flag_bad, data_bad, par_bad, pkg_bad, bg_bad, syn_nz;
    int cw [$];
    gpoly_t pg;
    logic [8*P-1:0] bt;
    pg = gen_poly(NPAR, FCR, 9'h11D);
    model_parity(v.pat);
    nb = ob_d.size() - b0;
    s0 = (v.abort_at > 0) ? v.abort_at : 0;
    flag_bad = 0; data_bad = 0; par_bad = 0; pkg_bad = 0; bg_bad = 0; syn_nz = 0;
    chk("beat_count", nb, v.exp_beats);
    for (int b = 0; b < nb && b < v.exp_beats; b++) begin
      logic [2:0] ef;
      bt = ob_d[b0 + b];
      ef = {(b == 0) || (v.abort_at > 0 && b == v.abort_at),
            (b == v.exp_beats - 1), (b >= v.exp_beats - PB)};
      if (ob_f[b0 + b] !== ef) flag_bad++;
      for (int l = 0; l < P; l++) begin
        int a;
        a = int'(bt[8*P-1-8*l -: 8]);
        if (b >= s0) cw.push_back(a);
        if (b < v.exp_beats - PB) begin
          if (v.abort_at > 0 && b < v.abort_at) begin
            if (a != sym(v.pre_pat, b*P + l)) data_bad++;
          end else if (a != sym(v.pat, (b - s0)*P + l)) data_bad++;
        end else begin
          int k;
          k = (b - (v.exp_beats - PB))*P + l;
          if (a != mpar[k]) par_bad++;
          if (a != int'(pg[NPAR-1-k])) pkg_bad++;
          if (a != bg[NPAR-1-k]) bg_bad++;
        end
      end
    end
    for (int i = 0; i < NPAR; i++) begin
      int acc, root;
      acc = 0;
      root = gexp[(FCR + i) % 255];
      foreach (cw[n]) acc = gfm(acc, root) ^ cw[n];
      if (acc != 0) syn_nz++;
    end
    chk("flag_errs", flag_bad, 0);
    chk("data_errs", data_bad, 0);
    chk("parity_errs", par_bad, 0);
    chk("syndrome_nonzero", syn_nz, 0);
    chk("frame_err_pulses", n_err - e0, v.exp_err);
    chk("ready_low_cycles", n_rdy_low - r0, v.exp_rdy_low);
    chk("latency_errs", n_lat_bad - l0, 0);
    if (v.pat == 1) begin
      chk("parity_vs_pkg_gen_poly", pkg_bad, 0);
      chk("parity_vs_bench_gen_poly", bg_bad, 0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int b0, e0, r0, l0, q0, t;
    b0 = ob_d.size(); e0 = n_err; r0 = n_rdy_low; l0 = n_lat_bad; q0 = n_eof;
    @(posedge clk);
    #1;
    if (v.abort_at > 0) drive_beats(v.pre_pat, v.abort_at, -1, -1);
    drive_beats(v.pat, KB, v.sa, v.sb);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    t = 0;
    while (n_eof == q0 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("eof_seen", n_eof - q0, 1);
    repeat (2) begin @(negedge clk); #1; end
    analyze(v, b0, e0, r0, l0);
  endtask

  vec_t tv [5];
  vec_t clean;

  initial begin
    int x, b0, e0, p0, t;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x;
      glog[x] = i;
      x = x << 1;
      if (x >= 256) x = x ^ 'h11D;
    end
    glog[0] = 0;
    for (int i = 0; i <= NPAR; i++) bg[i] = (i == 0) ? 1 : 0;
    for (int i = 0; i < NPAR; i++) begin
      int root;
      root = gexp[(FCR + i) % 255];
      for (int j = NPAR; j > 0; j--) bg[j] = bg[j-1] ^ gfm(bg[j], root);
      bg[0] = gfm(bg[0], root);
    end

    tv[0] = '{pat:0, pre_pat:0, abort_at:-1, sa:-1, sb:-1, exp_beats:63, exp_err:0, exp_rdy_low:4};
    tv[1] = '{pat:1, pre_pat:0, abort_at:-1, sa:-1, sb:-1, exp_beats:63, exp_err:0, exp_rdy_low:4};
    tv[2] = '{pat:2, pre_pat:0, abort_at:-1, sa:10, sb:40, exp_beats:63, exp_err:0, exp_rdy_low:4};
    tv[3] = '{pat:2, pre_pat:0, abort_at:-1, sa:-1, sb:-1, exp_beats:63, exp_err:0, exp_rdy_low:4};
    tv[4] = '{pat:3, pre_pat:2, abort_at:20, sa:-1, sb:-1, exp_beats:83, exp_err:1, exp_rdy_low:4};
    clean = '{pat:4, pre_pat:0, abort_at:-1, sa:-1, sb:-1, exp_beats:63, exp_err:0, exp_rdy_low:4};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dout", dout, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_flags", {out_sof, out_eof, out_parity}, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(tv[i]);

    // beat without start marker while idle is dropped
    b0 = ob_d.size(); e0 = n_err;
    @(posedge clk);
    #1;
    din = '1; in_valid = 1'b1; in_sof = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) begin @(negedge clk); #1; end
    chk("idle_drop_err", n_err - e0, 1);
    chk("idle_drop_beats", ob_d.size() - b0, 0);

    // reset while parity is being emitted
    p0 = n_par_seen;
    @(posedge clk);
    #1;
    drive_beats(3, KB, -1, -1);
    in_valid = 1'b0; in_sof = 1'b0;
    t = 0;
    while (n_par_seen - p0 < 2 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("rst_mid_wait", n_par_seen - p0, 2);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    rst = 1'b0;
    repeat (2) begin @(negedge clk); #1; end
    chk("rst_mid_parity_beats", n_par_seen - p0, 2);
    run_vec(clean);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
